// File: rtl/tp_sequencer.sv
// tp_sequencer: launches a pulse into the 11-tap delay line, turns the rising
// edges of taps 2/5/8/10 into fixed-width TP1-TP4 pulses, relaunches while
// running and flags a line that never returns its TP4 edge.
module tp_sequencer #(
  parameter int TP_WIDTH     = 10,
  parameter int LAUNCH_WIDTH = 5,
  parameter int TIMEOUT      = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  input  logic        clr_err,
  input  logic [10:0] tap,
  output logic        launch_n,
  output logic        tp1,
  output logic        tp2,
  output logic        tp3,
  output logic        tp4,
  output logic        busy,
  output logic        cycle_done,
  output logic        err_timeout,
  output logic [15:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic [3:0] TP_LOAD     = 4'(TP_WIDTH);
  localparam logic [3:0] LAUNCH_LAST = 4'(LAUNCH_WIDTH - 1);
  localparam logic [7:0] WD_LAST     = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [3:0]  tap_sel;
  logic [3:0]  tap_prev;
  logic [3:0]  tap_rise;
  logic [3:0]  arm;
  logic [3:0]  fire;
  logic        step_mode;
  logic [3:0]  launch_cnt;
  logic [7:0]  wd_cnt;
  logic [3:0]  tp_cnt [4];
  logic        start;
  logic        timeout_hit;
  logic        unused_tap_bits;

  // Only taps 2, 5, 8 and 10 generate timing pulses; bit j feeds tp(j+1).
  assign tap_sel         = {tap[10], tap[8], tap[5], tap[2]};
  assign unused_tap_bits = ^{tap[9], tap[7:6], tap[4:3], tap[1:0]};
  assign tap_rise        = tap_sel & ~tap_prev;

  assign busy        = (state != IDLE);
  assign fire        = busy ? (tap_rise & arm) : 4'b0000;
  assign timeout_hit = busy && (wd_cnt == WD_LAST) && !fire[3];

  assign tp1 = (tp_cnt[0] != 4'd0);
  assign tp2 = (tp_cnt[1] != 4'd0);
  assign tp3 = (tp_cnt[2] != 4'd0);
  assign tp4 = (tp_cnt[3] != 4'd0);

  // Next-state decode; a TP4 fire outranks a watchdog expiry on the same clock.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (!err_timeout && (run || step)) begin
          state_next = LAUNCH;
          start      = 1'b1;
        end
      end
      LAUNCH, WAIT: begin
        if (fire[3]) begin
          if (run && !step_mode) begin
            state_next = LAUNCH;
            start      = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (timeout_hit) begin
          state_next = IDLE;
        end else if ((state == LAUNCH) && (launch_cnt == LAUNCH_LAST)) begin
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; launch_n is registered so the delay line sees a clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      launch_n <= 1'b1;
    end else begin
      state    <= state_next;
      launch_n <= (state_next != LAUNCH);
    end
  end

  // Tap history for rising-edge detection, sampled every clock in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_prev <= 4'b0000;
    end else begin
      tap_prev <= tap_sel;
    end
  end

  // Per-cycle bookkeeping: arm flags, launch width counter and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_mode  <= 1'b0;
      arm        <= 4'b0000;
      launch_cnt <= 4'd0;
      wd_cnt     <= 8'd0;
    end else if (start) begin
      step_mode  <= !run;
      arm        <= 4'b1111;
      launch_cnt <= 4'd0;
      wd_cnt     <= 8'd0;
    end else begin
      if (timeout_hit) begin
        arm <= 4'b0000;
      end else begin
        arm <= arm & ~fire;
      end
      if (state == LAUNCH) begin
        launch_cnt <= launch_cnt + 4'd1;
      end
      if (busy) begin
        wd_cnt <= wd_cnt + 8'd1;
      end
    end
  end

  // Sticky error flag (set beats clear), cycle-done strobe and cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
      cycle_done  <= 1'b0;
      cycle_cnt   <= 16'd0;
    end else begin
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end else if (clr_err) begin
        err_timeout <= 1'b0;
      end
      cycle_done <= fire[3];
      if (fire[3]) begin
        cycle_cnt <= cycle_cnt + 16'd1;
      end
    end
  end

  // Pulse-width counters; a pulse runs to completion regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        tp_cnt[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fire[i]) begin
          tp_cnt[i] <= TP_LOAD;
        end else if (tp_cnt[i] != 4'd0) begin
          tp_cnt[i] <= tp_cnt[i] - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tp_sequencer.sv
// Testbench for tp_sequencer: directed phases plus randomized run/step/clr_err
// and tap activity, compared every clock against a timestamp-based model.
module tb_tp_sequencer;

  localparam int TP_WIDTH     = 10;
  localparam int LAUNCH_WIDTH = 5;
  localparam int TIMEOUT      = 80;

  localparam int M_IDEAL  = 0;
  localparam int M_RANDOM = 1;
  localparam int M_GLITCH = 2;
  localparam int M_ZERO   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        clr_err;
  logic [10:0] tap;
  logic        launch_n;
  logic        tp1, tp2, tp3, tp4;
  logic        busy;
  logic        cycle_done;
  logic        err_timeout;
  logic [15:0] cycle_cnt;
  logic [3:0]  tp_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: everything expressed as edge timestamps.
  int          t;
  bit          m_busy;
  bit          m_err;
  bit          m_step;
  bit   [3:0]  m_arm;
  int          m_launch_t;
  bit   [3:0]  m_tp_valid;
  int          m_tp_t [4];
  int          m_done_t;
  logic [15:0] m_cnt;
  logic [10:0] m_tap_prev;
  logic [63:0] lhist;

  assign tp_vec = {tp4, tp3, tp2, tp1};

  tp_sequencer #(
    .TP_WIDTH    (TP_WIDTH),
    .LAUNCH_WIDTH(LAUNCH_WIDTH),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .step       (step),
    .clr_err    (clr_err),
    .tap        (tap),
    .launch_n   (launch_n),
    .tp1        (tp1),
    .tp2        (tp2),
    .tp3        (tp3),
    .tp4        (tp4),
    .busy       (busy),
    .cycle_done (cycle_done),
    .err_timeout(err_timeout),
    .cycle_cnt  (cycle_cnt)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy     = 1'b0;
    m_err      = 1'b0;
    m_step     = 1'b0;
    m_arm      = 4'b0000;
    m_launch_t = -1000;
    m_tp_valid = 4'b0000;
    for (int j = 0; j < 4; j++) m_tp_t[j] = -1000;
    m_done_t   = -1000;
    m_cnt      = 16'd0;
    m_tap_prev = 11'd0;
  endfunction

  // Advance the model by one rising edge using the inputs held across it.
  function automatic void model_edge();
    logic [3:0] rise;
    logic [3:0] fired;
    bit         timed_out;
    t++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    timed_out = 1'b0;
    rise = {tap[10] & ~m_tap_prev[10], tap[8] & ~m_tap_prev[8],
            tap[5] & ~m_tap_prev[5], tap[2] & ~m_tap_prev[2]};
    m_tap_prev = tap;
    if (m_busy) begin
      fired = rise & m_arm;
      for (int j = 0; j < 4; j++) begin
        if (fired[j]) begin
          m_tp_valid[j] = 1'b1;
          m_tp_t[j]     = t;
        end
      end
      m_arm = m_arm & ~fired;
      if (fired[3]) begin
        m_cnt    = m_cnt + 16'd1;
        m_done_t = t;
        if (run && !m_step) begin
          m_launch_t = t;
          m_arm      = 4'b1111;
        end else begin
          m_busy = 1'b0;
        end
      end else if (t - m_launch_t == TIMEOUT) begin
        m_err     = 1'b1;
        m_arm     = 4'b0000;
        m_busy    = 1'b0;
        timed_out = 1'b1;
      end
    end else if (!m_err && (run || step)) begin
      m_busy     = 1'b1;
      m_launch_t = t;
      m_arm      = 4'b1111;
      m_step     = !run;
    end
    if (clr_err && !timed_out) m_err = 1'b0;
  endfunction

  // Compare every output against what the model predicts after the last edge.
  task automatic compare_all();
    bit exp_tp;
    check_output("launch_n", 16'(launch_n), 16'(!(m_busy && (t - m_launch_t) < LAUNCH_WIDTH)));
    for (int j = 0; j < 4; j++) begin
      exp_tp = m_tp_valid[j] && ((t - m_tp_t[j]) < TP_WIDTH);
      check_output($sformatf("tp%0d", j + 1), 16'(tp_vec[j]), 16'(exp_tp));
    end
    check_output("busy", 16'(busy), 16'(m_busy));
    check_output("cycle_done", 16'(cycle_done), 16'(m_done_t == t));
    check_output("err_timeout", 16'(err_timeout), 16'(m_err));
    check_output("cycle_cnt", cycle_cnt, m_cnt);
  endtask

  // Drive taps (and optionally control inputs) for the next edge.
  task automatic apply_stimulus(input int mode, input bit rand_ctl);
    logic [10:0] ideal;
    logic [10:0] mask;
    lhist = {lhist[62:0], ~launch_n};
    for (int i = 0; i < 11; i++) begin
      ideal[i] = lhist[5 * i + 1];
    end
    case (mode)
      M_IDEAL: tap = ideal;
      M_RANDOM: begin
        for (int i = 0; i < 11; i++) mask[i] = ($urandom_range(5) == 0);
        tap = tap ^ mask;
      end
      M_GLITCH: begin
        for (int i = 0; i < 11; i++) mask[i] = ($urandom_range(39) == 0);
        tap = ideal ^ mask;
      end
      default: tap = 11'd0;
    endcase
    if (rand_ctl) begin
      if ($urandom_range(149) == 0) run = ~run;
      step    = ($urandom_range(24) == 0);
      clr_err = ($urandom_range(39) == 0);
    end
  endtask

  task automatic run_cycles(input int n, input int mode, input bit rand_ctl);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      apply_stimulus(mode, rand_ctl);
    end
  endtask

  // Directed phases followed by randomized traffic.
  initial begin
    bit found;
    rst_n   = 1'b0;
    run     = 1'b1;
    step    = 1'b0;
    clr_err = 1'b0;
    tap     = 11'h7FF;
    lhist   = 64'd0;
    t       = 0;
    model_reset();

    repeat (3) begin
      @(negedge clk);
      compare_all();
    end
    rst_n = 1'b1;

    run_cycles(180, M_IDEAL, 1'b0);
    run = 1'b0;
    run_cycles(80, M_IDEAL, 1'b0);

    step = 1'b1;
    run_cycles(1, M_IDEAL, 1'b0);
    step = 1'b0;
    run_cycles(70, M_IDEAL, 1'b0);

    run = 1'b1;
    run_cycles(100, M_ZERO, 1'b0);
    clr_err = 1'b1;
    run_cycles(1, M_ZERO, 1'b0);
    clr_err = 1'b0;
    run_cycles(100, M_ZERO, 1'b0);
    run     = 1'b0;
    clr_err = 1'b1;
    run_cycles(1, M_ZERO, 1'b0);
    clr_err = 1'b0;
    run_cycles(5, M_ZERO, 1'b0);

    run_cycles(3000, M_RANDOM, 1'b1);
    run_cycles(3000, M_GLITCH, 1'b1);
    run_cycles(2000, M_IDEAL, 1'b1);

    clr_err = 1'b1;
    run     = 1'b1;
    step    = 1'b0;
    run_cycles(1, M_IDEAL, 1'b0);
    clr_err = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      run_cycles(1, M_IDEAL, 1'b0);
      if (m_tp_valid[1] && ((t - m_tp_t[1]) >= 2) && ((t - m_tp_t[1]) <= 6)) found = 1'b1;
    end
    check_output("tp2_window_reached", 16'(found), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(120, M_IDEAL, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
